// File: rtl/serial_asm_pkg.sv
// Shared types and sizing helpers for the serial byte assembler.
// The PARITY state is only reachable when PARITY_CHECK_EN is defined.
package serial_asm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    LOAD   = 2'd3
  } asm_state_t;

  // Counter width big enough for both the bit index and the idle-cycle count
  function automatic int cnt_width(input int width, input int timeout);
    int m;
    m = (width > timeout + 1) ? width : timeout + 1;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  localparam int DEF_CNT_W = cnt_width(8, 16);

endpackage

// File: rtl/asm_timeout_ctr.sv
// Idle-cycle watchdog for an in-progress frame. Counts enabled cycles and
// flags expire on the cycle whose count would reach TIMEOUT.
module asm_timeout_ctr
  import serial_asm_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CW      = DEF_CNT_W
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // Expire is combinational so the FSM can abort on the same edge the count hits TIMEOUT
  assign expire = enable && (count == LAST);

  // Count idle cycles, restarting whenever the frame makes progress or ends
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= expire ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/serial_byte_assembler.sv
// Collects a framed serial bit stream and presents WIDTH bits in parallel with a
// one-cycle load strobe for the downstream parallel-load register.
// Optional even-parity trailer bit is enabled by defining PARITY_CHECK_EN.
module serial_byte_assembler
  import serial_asm_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  parameter int TIMEOUT   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ser_in,
  input  logic             bit_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] par_data,
  output logic             load,
  output logic             busy,
  output logic             frame_err,
  output logic [7:0]       frame_cnt
);

  localparam int CW = cnt_width(WIDTH, TIMEOUT);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  asm_state_t       state;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] next_shift;
  logic [CW-1:0]    bit_cnt;
  logic             in_frame;
  logic             tmo_clear;
  logic             tmo_enable;
  logic             tmo_expire;
  logic             last_bit;
`ifdef PARITY_CHECK_EN
  logic             parity_ok;
`endif

  // Shift register contents after accepting ser_in in the configured bit order
  always_comb begin
    next_shift = shift_reg;
    if (MSB_FIRST != 0) begin
      next_shift = {shift_reg[WIDTH-2:0], ser_in};
    end else begin
      next_shift = {ser_in, shift_reg[WIDTH-1:1]};
    end
  end

  assign in_frame   = (state == SHIFT) || (state == PARITY);
  assign tmo_clear  = !in_frame || sof || bit_valid;
  assign tmo_enable = in_frame && !sof && !bit_valid;
  assign last_bit   = (bit_cnt == LAST_BIT);
  assign busy       = (state != IDLE);
`ifdef PARITY_CHECK_EN
  assign parity_ok  = ((^shift_reg) ^ ser_in) == 1'b0;
`endif

  asm_timeout_ctr #(
    .TIMEOUT (TIMEOUT),
    .CW      (CW)
  ) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .clear  (tmo_clear),
    .enable (tmo_enable),
    .expire (tmo_expire)
  );

  // Frame FSM: sof beats bit_valid beats timeout; load and frame_err are single-cycle pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      par_data  <= '0;
      load      <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= 8'd0;
    end else begin
      load      <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (sof) begin
            state     <= SHIFT;
            bit_cnt   <= '0;
            shift_reg <= '0;
          end
        end
        SHIFT: begin
          if (sof) begin
            frame_err <= 1'b1;
            bit_cnt   <= '0;
            shift_reg <= '0;
          end else if (bit_valid) begin
            shift_reg <= next_shift;
            bit_cnt   <= bit_cnt + CW'(1);
            if (last_bit) begin
`ifdef PARITY_CHECK_EN
              state     <= PARITY;
`else
              state     <= LOAD;
              par_data  <= next_shift;
              load      <= 1'b1;
              frame_cnt <= frame_cnt + 8'd1;
`endif
            end
          end else if (tmo_expire) begin
            state     <= IDLE;
            frame_err <= 1'b1;
          end
        end
`ifdef PARITY_CHECK_EN
        PARITY: begin
          if (sof) begin
            state     <= SHIFT;
            frame_err <= 1'b1;
            bit_cnt   <= '0;
            shift_reg <= '0;
          end else if (bit_valid) begin
            if (parity_ok) begin
              state     <= LOAD;
              par_data  <= shift_reg;
              load      <= 1'b1;
              frame_cnt <= frame_cnt + 8'd1;
            end else begin
              state     <= IDLE;
              frame_err <= 1'b1;
            end
          end else if (tmo_expire) begin
            state     <= IDLE;
            frame_err <= 1'b1;
          end
        end
`endif
        LOAD: begin
          if (sof) begin
            state     <= SHIFT;
            bit_cnt   <= '0;
            shift_reg <= '0;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_byte_assembler.sv
// Directed bench for serial_byte_assembler: one MSB-first and one LSB-first
// instance share the same stimulus. Honours PARITY_CHECK_EN when defined.
module tb_serial_byte_assembler;

  logic       clock;
  logic       reset;
  logic       ser_in;
  logic       bit_valid;
  logic       sof;
  logic [7:0] par_m, par_l;
  logic       load_m, load_l;
  logic       busy_m, busy_l;
  logic       err_m, err_l;
  logic [7:0] cnt_m, cnt_l;

  int total = 0;
  int bad   = 0;
  int cycle = 0;
  int last_load = 0;
  int prev_load = 0;

  typedef struct {
    logic       s, v, d;
    logic       e_load, e_busy, e_err;
    logic [7:0] e_msb, e_lsb, e_cnt;
  } vec_t;

  vec_t tbl[$];

  serial_byte_assembler #(.WIDTH(8), .MSB_FIRST(1), .TIMEOUT(16)) dut_msb (
    .clock(clock), .reset(reset), .ser_in(ser_in), .bit_valid(bit_valid), .sof(sof),
    .par_data(par_m), .load(load_m), .busy(busy_m), .frame_err(err_m), .frame_cnt(cnt_m)
  );

  serial_byte_assembler #(.WIDTH(8), .MSB_FIRST(0), .TIMEOUT(16)) dut_lsb (
    .clock(clock), .reset(reset), .ser_in(ser_in), .bit_valid(bit_valid), .sof(sof),
    .par_data(par_l), .load(load_l), .busy(busy_l), .frame_err(err_l), .frame_cnt(cnt_l)
  );

  // 10-unit clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hard stop in case the stimulus ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one cycle of inputs and sample outputs 1 unit after the edge
  task automatic applyStimulus(input logic r, input logic s, input logic v, input logic d);
    reset     = r;
    sof       = s;
    bit_valid = v;
    ser_in    = d;
    @(posedge clock);
    #1;
    cycle++;
    if (load_m === 1'b1) begin
      prev_load = last_load;
      last_load = cycle;
    end
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Eight data bits MSB of data first, then the parity trailer when enabled
  task automatic sendFrame(input logic [7:0] data, input logic bad_par);
    for (int i = 7; i >= 0; i--) applyStimulus(1'b0, 1'b0, 1'b1, data[i]);
`ifdef PARITY_CHECK_EN
    applyStimulus(1'b0, 1'b0, 1'b1, (^data) ^ bad_par);
`endif
  endtask

  function automatic void addRow(input logic s, v, d, e_load, e_busy, e_err,
                                 input logic [7:0] e_msb, e_lsb, e_cnt);
    vec_t r;
    r.s = s; r.v = v; r.d = d;
    r.e_load = e_load; r.e_busy = e_busy; r.e_err = e_err;
    r.e_msb = e_msb; r.e_lsb = e_lsb; r.e_cnt = e_cnt;
    tbl.push_back(r);
  endfunction

  // One complete frame: sof, bits, optional parity, then an idle cycle
  function automatic void addFrame(input logic [7:0] bits, input logic par_bit,
                                   input logic [7:0] pm, pl, new_m, new_l,
                                   input logic [7:0] cnt_before);
    addRow(1, 0, 0, 0, 1, 0, pm, pl, cnt_before);
    for (int i = 7; i >= 1; i--) addRow(0, 1, bits[i], 0, 1, 0, pm, pl, cnt_before);
`ifdef PARITY_CHECK_EN
    addRow(0, 1, bits[0], 0, 1, 0, pm, pl, cnt_before);
    addRow(0, 1, par_bit, 1, 1, 0, new_m, new_l, cnt_before + 8'd1);
`else
    addRow(0, 1, bits[0], 1, 1, 0, new_m, new_l, cnt_before + 8'd1);
`endif
    addRow(0, 0, 0, 0, 0, 0, new_m, new_l, cnt_before + 8'd1);
  endfunction

  initial begin
    reset = 1'b1; sof = 1'b0; bit_valid = 1'b0; ser_in = 1'b0;

    // Reset state
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("reset par_msb", par_m, 8'h00);
    checkOutput("reset par_lsb", par_l, 8'h00);
    checkOutput("reset load", {7'd0, load_m}, 8'h00);
    checkOutput("reset busy", {7'd0, busy_m}, 8'h00);
    checkOutput("reset err", {7'd0, err_m}, 8'h00);
    checkOutput("reset cnt", cnt_m, 8'h00);

    // Table: A5 (palindrome in both orders), then E0 which is 07 when LSB-first
    addFrame(8'hA5, 1'b0, 8'h00, 8'h00, 8'hA5, 8'hA5, 8'd0);
    addFrame(8'hE0, 1'b1, 8'hA5, 8'hA5, 8'hE0, 8'h07, 8'd1);
    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(1'b0, tbl[i].s, tbl[i].v, tbl[i].d);
      checkOutput($sformatf("row%0d load", i), {7'd0, load_m}, {7'd0, tbl[i].e_load});
      checkOutput($sformatf("row%0d load_lsb", i), {7'd0, load_l}, {7'd0, tbl[i].e_load});
      checkOutput($sformatf("row%0d busy", i), {7'd0, busy_m}, {7'd0, tbl[i].e_busy});
      checkOutput($sformatf("row%0d err", i), {7'd0, err_m}, {7'd0, tbl[i].e_err});
      checkOutput($sformatf("row%0d par_msb", i), par_m, tbl[i].e_msb);
      checkOutput($sformatf("row%0d par_lsb", i), par_l, tbl[i].e_lsb);
      checkOutput($sformatf("row%0d cnt", i), cnt_m, tbl[i].e_cnt);
    end

    // Timeout: sof, 3 bits, then 16 idle cycles
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("tmo err before", {7'd0, err_m}, 8'h00);
    checkOutput("tmo busy before", {7'd0, busy_m}, 8'h01);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("tmo err", {7'd0, err_m}, 8'h01);
    checkOutput("tmo busy", {7'd0, busy_m}, 8'h00);
    checkOutput("tmo load", {7'd0, load_m}, 8'h00);
    checkOutput("tmo par", par_m, 8'hE0);
    checkOutput("tmo cnt", cnt_m, 8'd2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("tmo err pulse", {7'd0, err_m}, 8'h00);

    // Restart: sof, 5 bits, sof with a discarded bit, then 3C
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("restart err", {7'd0, err_m}, 8'h01);
    checkOutput("restart busy", {7'd0, busy_m}, 8'h01);
    sendFrame(8'h3C, 1'b0);
    checkOutput("restart load", {7'd0, load_m}, 8'h01);
    checkOutput("restart err2", {7'd0, err_m}, 8'h00);
    checkOutput("restart par_msb", par_m, 8'h3C);
    checkOutput("restart par_lsb", par_l, 8'h3C);
    checkOutput("restart cnt", cnt_m, 8'd3);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Back-to-back: sof in the LOAD cycle of FF, then 00
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    sendFrame(8'hFF, 1'b0);
    checkOutput("b2b load1", {7'd0, load_m}, 8'h01);
    checkOutput("b2b par1", par_m, 8'hFF);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("b2b busy", {7'd0, busy_m}, 8'h01);
    checkOutput("b2b load off", {7'd0, load_m}, 8'h00);
    sendFrame(8'h00, 1'b0);
    checkOutput("b2b load2", {7'd0, load_m}, 8'h01);
    checkOutput("b2b par2", par_m, 8'h00);
    checkOutput("b2b cnt", cnt_m, 8'd5);
`ifdef PARITY_CHECK_EN
    checkOutput("b2b gap", 8'(last_load - prev_load), 8'd10);
`else
    checkOutput("b2b gap", 8'(last_load - prev_load), 8'd9);
`endif
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset mid-frame clears everything next cycle
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("midrst par", par_m, 8'h00);
    checkOutput("midrst par_lsb", par_l, 8'h00);
    checkOutput("midrst busy", {7'd0, busy_m}, 8'h00);
    checkOutput("midrst load", {7'd0, load_m}, 8'h00);
    checkOutput("midrst err", {7'd0, err_m}, 8'h00);
    checkOutput("midrst cnt", cnt_m, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

`ifdef PARITY_CHECK_EN
    // Good parity on 3C, then bad parity on A5 must leave 3C in place
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    sendFrame(8'h3C, 1'b0);
    checkOutput("par good load", {7'd0, load_m}, 8'h01);
    checkOutput("par good data", par_m, 8'h3C);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    sendFrame(8'hA5, 1'b1);
    checkOutput("par bad err", {7'd0, err_m}, 8'h01);
    checkOutput("par bad load", {7'd0, load_m}, 8'h00);
    checkOutput("par bad data", par_m, 8'h3C);
    checkOutput("par bad cnt", cnt_m, 8'd1);
    checkOutput("par bad busy", {7'd0, busy_m}, 8'h00);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
